// File: rtl/issue_hazard_ctrl.sv
// rtl/issue_hazard_ctrl.sv - issue-stage load-use scoreboard, multi-cycle and flush hazard controller
module issue_hazard_ctrl #(
   parameter int NUM_REGS   = 32,
   parameter int LOAD_LAT   = 2,
   parameter int CNT_W      = 2,
   parameter int FLUSH_HOLD = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       is_valid_i,
   input  logic [4:0] is_rj_i,
   input  logic [4:0] is_rkd_i,
   input  logic       is_rj_use_i,
   input  logic       is_rkd_use_i,
   input  logic       is_gr_we_i,
   input  logic [4:0] is_dest_i,
   input  logic       is_res_from_mem_i,
   input  logic       is_multicycle_i,
   input  logic       es_allowin_i,
   input  logic       pipe_adv_i,
   input  logic       mc_done_i,
   input  logic       flush_req_i,
   output logic       is_stall_o,
   output logic       is_flush_o,
   output logic       issue_go_o,
   output logic [1:0] stall_cause_o,
   output logic       sb_busy_o
);

   localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MC_BUSY = 2'd1,
      ST_FLUSH   = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [HOLD_W-1:0]   hold;
   logic [HOLD_W-1:0]   hold_next;
   logic                flush_q;

   // Entry 0 exists only so 5-bit indices map directly; it is pinned to zero.
   logic [CNT_W-1:0]    cnt [NUM_REGS];

   logic                hazard_rj;
   logic                hazard_rkd;
   logic                hazard;
   logic                load_set;
   logic                stall;
   logic                go;

   // Source hazard: a read, nonzero source whose producing load is still in flight.
   always_comb begin
      hazard_rj  = is_rj_use_i  && (is_rj_i  != 5'd0) && (cnt[is_rj_i]  != '0);
      hazard_rkd = is_rkd_use_i && (is_rkd_i != 5'd0) && (cnt[is_rkd_i] != '0);
      hazard     = hazard_rj || hazard_rkd;
   end

   // Stall and issue strobe; issue is judged against the current FSM state only.
   always_comb begin
      stall    = (state != ST_IDLE) || (is_valid_i && hazard);
      go       = is_valid_i && es_allowin_i && !stall;
      load_set = go && is_res_from_mem_i && is_gr_we_i && (is_dest_i != 5'd0);
   end

   // Stall cause priority: flush recovery, then multi-cycle op, then load-use.
   always_comb begin
      stall_cause_o = 2'b00;
      if (state == ST_FLUSH) begin
         stall_cause_o = 2'b11;
      end else if (state == ST_MC_BUSY) begin
         stall_cause_o = 2'b10;
      end else if (is_valid_i && hazard) begin
         stall_cause_o = 2'b01;
      end
   end

   // Scoreboard counters: a new load sets LOAD_LAT and beats the same-cycle decrement.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (i == 0) begin
               cnt[i] <= '0;
            end else if (load_set && (is_dest_i == 5'(i))) begin
               cnt[i] <= CNT_W'(LOAD_LAT);
            end else if (pipe_adv_i && (cnt[i] != '0)) begin
               cnt[i] <= cnt[i] - CNT_W'(1);
            end
         end
      end
   end

   // Scoreboard busy: any register still waiting on load data.
   always_comb begin
      sb_busy_o = 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
         sb_busy_o = sb_busy_o || (cnt[i] != '0);
      end
   end

   // Next state: flush beats everything, including a same-cycle multi-cycle issue.
   always_comb begin
      state_next = state;
      hold_next  = hold;
      case (state)
         ST_IDLE: begin
            if (flush_req_i) begin
               state_next = ST_FLUSH;
               hold_next  = HOLD_W'(FLUSH_HOLD);
            end else if (go && is_multicycle_i) begin
               state_next = ST_MC_BUSY;
            end
         end
         ST_MC_BUSY: begin
            if (flush_req_i) begin
               state_next = ST_FLUSH;
               hold_next  = HOLD_W'(FLUSH_HOLD);
            end else if (mc_done_i) begin
               state_next = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (flush_req_i) begin
               hold_next = HOLD_W'(FLUSH_HOLD);
            end else if (hold <= HOLD_W'(1)) begin
               state_next = ST_IDLE;
               hold_next  = '0;
            end else begin
               hold_next = hold - HOLD_W'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
            hold_next  = '0;
         end
      endcase
   end

   // FSM state and flush-hold register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         hold  <= '0;
      end else begin
         state <= state_next;
         hold  <= hold_next;
      end
   end

   // Flush pulse to IQ/IS, one cycle after each request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flush_q <= 1'b0;
      end else begin
         flush_q <= flush_req_i;
      end
   end

   assign is_stall_o = stall;
   assign issue_go_o = go;
   assign is_flush_o = flush_q;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// tb/tb_issue_hazard_ctrl.sv - directed scoreboard bench for issue_hazard_ctrl
module tb_issue_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       is_valid_i;
   logic [4:0] is_rj_i;
   logic [4:0] is_rkd_i;
   logic       is_rj_use_i;
   logic       is_rkd_use_i;
   logic       is_gr_we_i;
   logic [4:0] is_dest_i;
   logic       is_res_from_mem_i;
   logic       is_multicycle_i;
   logic       es_allowin_i;
   logic       pipe_adv_i;
   logic       mc_done_i;
   logic       flush_req_i;
   logic       is_stall_o;
   logic       is_flush_o;
   logic       issue_go_o;
   logic [1:0] stall_cause_o;
   logic       sb_busy_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic       stall;
      logic       flush;
      logic       go;
      logic [1:0] cause;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];

   issue_hazard_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .is_valid_i        (is_valid_i),
      .is_rj_i           (is_rj_i),
      .is_rkd_i          (is_rkd_i),
      .is_rj_use_i       (is_rj_use_i),
      .is_rkd_use_i      (is_rkd_use_i),
      .is_gr_we_i        (is_gr_we_i),
      .is_dest_i         (is_dest_i),
      .is_res_from_mem_i (is_res_from_mem_i),
      .is_multicycle_i   (is_multicycle_i),
      .es_allowin_i      (es_allowin_i),
      .pipe_adv_i        (pipe_adv_i),
      .mc_done_i         (mc_done_i),
      .flush_req_i       (flush_req_i),
      .is_stall_o        (is_stall_o),
      .is_flush_o        (is_flush_o),
      .issue_go_o        (issue_go_o),
      .stall_cause_o     (stall_cause_o),
      .sb_busy_o         (sb_busy_o)
   );

   always #5 clk = ~clk;

   task automatic clear();
      is_valid_i        = 1'b0;
      is_rj_i           = 5'd0;
      is_rkd_i          = 5'd0;
      is_rj_use_i       = 1'b0;
      is_rkd_use_i      = 1'b0;
      is_gr_we_i        = 1'b0;
      is_dest_i         = 5'd0;
      is_res_from_mem_i = 1'b0;
      is_multicycle_i   = 1'b0;
      es_allowin_i      = 1'b1;
      pipe_adv_i        = 1'b0;
      mc_done_i         = 1'b0;
      flush_req_i       = 1'b0;
   endtask

   task automatic load(input logic [4:0] dest, input logic adv);
      clear();
      is_valid_i        = 1'b1;
      is_gr_we_i        = 1'b1;
      is_res_from_mem_i = 1'b1;
      is_dest_i         = dest;
      pipe_adv_i        = adv;
   endtask

   task automatic chk(input string tag, input string field, input logic [1:0] obs, input logic [1:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s.%s: observed %0b expected %0b", tag, field, obs, req);
      end
   endtask

   task automatic step(input string tag, input logic stall, input logic flush, input logic go,
                       input logic [1:0] cause, input logic busy);
      exp_t e;
      exp_t got;
      e.tag = tag; e.stall = stall; e.flush = flush; e.go = go; e.cause = cause; e.busy = busy;
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      chk(got.tag, "stall", {1'b0, is_stall_o}, {1'b0, got.stall});
      chk(got.tag, "flush", {1'b0, is_flush_o}, {1'b0, got.flush});
      chk(got.tag, "go",    {1'b0, issue_go_o}, {1'b0, got.go});
      chk(got.tag, "cause", stall_cause_o,      got.cause);
      chk(got.tag, "busy",  {1'b0, sb_busy_o},  {1'b0, got.busy});
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      clear();
      step("reset", 0, 0, 0, 2'b00, 0);
      reset = 1'b0;

      load(5'd5, 1'b1);
      step("ld_r5", 0, 0, 1, 2'b00, 0);
      clear(); is_valid_i = 1; is_rj_i = 5; is_rj_use_i = 1; pipe_adv_i = 1;
      step("use_r5_a", 1, 0, 0, 2'b01, 1);
      step("use_r5_b", 1, 0, 0, 2'b01, 1);
      step("use_r5_go", 0, 0, 1, 2'b00, 0);

      load(5'd5, 1'b0);
      step("ld_r5_noadv", 0, 0, 1, 2'b00, 0);
      clear(); is_valid_i = 1; is_rkd_i = 5; is_rkd_use_i = 1;
      for (int i = 0; i < 3; i++) step("hold_noadv", 1, 0, 0, 2'b01, 1);
      clear(); is_valid_i = 1; is_rkd_i = 5; is_rj_i = 5;
      step("nouse_r5", 0, 0, 1, 2'b00, 1);
      clear(); is_rkd_i = 5; is_rkd_use_i = 1;
      step("invalid_r5", 0, 0, 0, 2'b00, 1);
      clear(); is_valid_i = 1; es_allowin_i = 0; is_rj_i = 3; is_rj_use_i = 1;
      step("noallow", 0, 0, 0, 2'b00, 1);
      clear(); is_valid_i = 1; is_rkd_i = 5; is_rkd_use_i = 1; pipe_adv_i = 1;
      step("drain_a", 1, 0, 0, 2'b01, 1);
      step("drain_b", 1, 0, 0, 2'b01, 1);
      step("drain_go", 0, 0, 1, 2'b00, 0);

      load(5'd0, 1'b1);
      step("ld_r0", 0, 0, 1, 2'b00, 0);
      clear(); is_valid_i = 1; is_rj_use_i = 1; is_rkd_use_i = 1; pipe_adv_i = 1;
      step("use_r0", 0, 0, 1, 2'b00, 0);

      load(5'd6, 1'b0);
      step("ld_r6", 0, 0, 1, 2'b00, 0);
      clear(); pipe_adv_i = 1;
      step("adv_only", 0, 0, 0, 2'b00, 1);
      load(5'd6, 1'b1);
      step("reload_r6", 0, 0, 1, 2'b00, 1);
      clear(); is_valid_i = 1; is_rj_i = 6; is_rj_use_i = 1; pipe_adv_i = 1;
      step("use_r6_a", 1, 0, 0, 2'b01, 1);
      step("use_r6_b", 1, 0, 0, 2'b01, 1);
      step("use_r6_go", 0, 0, 1, 2'b00, 0);

      clear(); is_valid_i = 1; is_multicycle_i = 1;
      step("div_issue", 0, 0, 1, 2'b00, 0);
      for (int i = 1; i <= 10; i++) begin
         clear(); is_valid_i = 1; mc_done_i = (i == 10);
         step("mc_busy", 1, 0, 0, 2'b10, 0);
      end
      clear(); is_valid_i = 1;
      step("mc_after", 0, 0, 1, 2'b00, 0);

      clear(); is_valid_i = 1; is_multicycle_i = 1;
      step("div2", 0, 0, 1, 2'b00, 0);
      clear(); is_valid_i = 1; flush_req_i = 1;
      step("mc_flush", 1, 0, 0, 2'b10, 0);
      clear(); is_valid_i = 1;
      step("flush_hold", 1, 1, 0, 2'b11, 0);
      clear(); is_valid_i = 1; mc_done_i = 1;
      step("post_flush", 0, 0, 1, 2'b00, 0);
      clear(); is_valid_i = 1;
      step("post_flush2", 0, 0, 1, 2'b00, 0);

      load(5'd9, 1'b0); is_multicycle_i = 1; flush_req_i = 1;
      step("flush_and_issue", 0, 0, 1, 2'b00, 0);
      clear(); is_valid_i = 1; flush_req_i = 1;
      step("reflush", 1, 1, 0, 2'b11, 1);
      clear(); is_valid_i = 1;
      step("reflush_hold", 1, 1, 0, 2'b11, 1);
      step("flush_done", 0, 0, 1, 2'b00, 1);
      clear(); pipe_adv_i = 1;
      step("drain9_a", 0, 0, 0, 2'b00, 1);
      step("drain9_b", 0, 0, 0, 2'b00, 1);
      step("drain9_c", 0, 0, 0, 2'b00, 0);

      load(5'd7, 1'b0);
      step("ld_r7", 0, 0, 1, 2'b00, 0);
      clear(); is_valid_i = 1; is_multicycle_i = 1; pipe_adv_i = 1;
      step("div3", 0, 0, 1, 2'b00, 1);
      clear(); is_valid_i = 1;
      step("mc_r7", 1, 0, 0, 2'b10, 1);
      clear(); reset = 1'b1;
      step("async_reset", 0, 0, 0, 2'b00, 0);
      reset = 1'b0; is_valid_i = 1;
      step("after_reset", 0, 0, 1, 2'b00, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/issue_hazard_ctrl.md
Name: issue_hazard_ctrl

Overview:
Hazard controller for the issue stage. It owns a per-register load-use scoreboard and a small FSM that covers multi-cycle execute ops and flush recovery. From these it produces the issue-stage stall and flush controls (is_stall, is_flush) and the single-cycle issue strobe. It sits beside the IS stage and consumes the IS-to-hazard register indices plus pipeline-advance and flush requests.

Parameters:
NUM_REGS, 32, architectural GPR count; r0 never tracked
LOAD_LAT, 2, pipeline advances after issue before load data is forwardable (ES, MS)
CNT_W, 2, scoreboard counter width; must hold LOAD_LAT
FLUSH_HOLD, 1, cycles issue stays blocked after a flush

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
is_valid_i  in  1  IQ head holds a valid instruction
is_rj_i  in  5  source 1 index
is_rkd_i  in  5  source 2 index
is_rj_use_i  in  1  source 1 is read
is_rkd_use_i  in  1  source 2 is read
is_gr_we_i  in  1  head instruction writes GPR
is_dest_i  in  5  head destination
is_res_from_mem_i  in  1  head is a load
is_multicycle_i  in  1  head is a multi-cycle op (div/mod)
es_allowin_i  in  1  ES can accept
pipe_adv_i  in  1  ES→MS→WS advanced this cycle
mc_done_i  in  1  multi-cycle unit result ready (pulse)
flush_req_i  in  1  branch mispredict / exception flush request (pulse)
is_stall_o  out  1  blocks IS issue
is_flush_o  out  1  flush to IQ and IS valid
issue_go_o  out  1  head issues this cycle
stall_cause_o  out  2  00 none, 01 load-use, 10 multi-cycle, 11 flush
sb_busy_o  out  1  any scoreboard counter nonzero

Behaviour:
- Reset (async): all counters 0, FSM=IDLE, hold counter 0. Outputs: is_stall_o=0, is_flush_o=0, issue_go_o=0, stall_cause_o=00, sb_busy_o=0.
- Scoreboard: NUM_REGS-1 counters of CNT_W bits (r1..r31).
  - Hazard: the used source rj (or rkd) is nonzero and cnt[src]!=0.
  - Set: on issue_go_o with is_res_from_mem_i & is_gr_we_i & is_dest_i!=0, cnt[dest] ← LOAD_LAT.
  - Decrement: every nonzero counter decrements by 1 on cycles with pipe_adv_i=1; saturates at 0.
  - Set wins over decrement on the same register in the same cycle.
- issue_go_o = is_valid_i & es_allowin_i & ~is_stall_o (combinational).
- is_stall_o (combinational) = (FSM!=IDLE) | (is_valid_i & hazard).
  - stall_cause_o priority: flush > multi-cycle > load-use.
- FSM states:
  - IDLE.
    - flush_req_i → FLUSH.
    - Else issue_go_o & is_multicycle_i → MC_BUSY.
  - MC_BUSY: stall. mc_done_i → IDLE (issue may resume next cycle). flush_req_i → FLUSH (abandons the op).
  - FLUSH: hold counter ← FLUSH_HOLD on entry. Decrement each cycle; at 0 → IDLE.
- is_flush_o: registered. Asserted exactly 1 cycle after flush_req_i, for 1 cycle. A second flush_req_i during FLUSH re-arms the hold counter and pulses is_flush_o again.
- Flush does not clear the scoreboard: loads already issued are older than the flusher and still retire. Counters keep decrementing normally.
- Simultaneous flush_req_i and issue in the same cycle: flush wins.
  - issue_go_o is still computed from the current state. The issued op is killed downstream.
  - The scoreboard set still happens (conservative, harmless).
  - The FSM goes to FLUSH, never MC_BUSY.
- A source equal to r0, or a source whose use bit is 0, never stalls.
- sb_busy_o = OR of all counters.

Test Plan:
- Load to r5 issues, next head reads r5 with pipe_adv_i=1 each cycle → is_stall_o=1, cause=01 for 2 cycles, then issue_go_o=1 on the 3rd cycle.
- Load to r5 issues, pipe_adv_i held 0 for 3 cycles → stall persists 3 extra cycles; cnt[5] stays 2.
- Load to r0, then a consumer of r0 → no stall; sb_busy_o=0.
- Div issues; mc_done_i arrives 10 cycles later → stall with cause=10 for 10 cycles; IDLE on cycle 11.
- flush_req_i in MC_BUSY → is_flush_o pulses the next cycle; cause=11 for FLUSH_HOLD cycles; then IDLE, MC_BUSY not resumed.
- Assert reset mid-MC_BUSY with cnt[7]=1 → all outputs 0 immediately (asynchronous); sb_busy_o=0.
